// File: rtl/sca_exec_window_ctrl_if.sv
// Bus bundle between the local-bus interface block, the execution-window
// controller and the polynomial arithmetic unit. The master side is the
// host/unit environment; the slave side is the controller itself.
interface sca_exec_window_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 8
);
  // Host request and run configuration
  logic              start;
  logic [CNT_W-1:0]  cfg_delay;
  logic [CNT_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  cfg_gap;
  logic [CNT_W-1:0]  cfg_reps;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  // Arithmetic unit return path
  logic              dut_valid;
  logic [DATA_W-1:0] dut_o0;
  // Controller outputs
  logic              dut_enable;
  logic [DATA_W-1:0] dut_a;
  logic [DATA_W-1:0] dut_b;
  logic              trig;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              result_vld;
  logic [CNT_W-1:0]  valid_cnt;
  logic              overrun;

  modport master (
    output start, cfg_delay, cfg_len, cfg_gap, cfg_reps, op_a, op_b,
    output dut_valid, dut_o0,
    input  dut_enable, dut_a, dut_b, trig, busy, done,
    input  result, result_vld, valid_cnt, overrun
  );

  modport slave (
    input  start, cfg_delay, cfg_len, cfg_gap, cfg_reps, op_a, op_b,
    input  dut_valid, dut_o0,
    output dut_enable, dut_a, dut_b, trig, busy, done,
    output result, result_vld, valid_cnt, overrun
  );
endinterface

// File: rtl/sca_exec_window_ctrl.sv
// Programmable execution-window sequencer for side-channel measurement:
// start -> delay -> N enable windows separated by gaps -> done pulse.
// Operands are frozen per run, a scope trigger is generated and unit
// results are captured while the run is in progress.
module sca_exec_window_ctrl #(
  parameter int DATA_W   = 24,
  parameter int CNT_W    = 8,
  parameter int TRIG_ALL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sca_exec_window_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    ACTIVE = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic             TRIG_EVERY = (TRIG_ALL != 0);

  // A zero length or repetition count means "one".
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    at_least_one = (v == CNT_ZERO) ? CNT_ONE : v;
  endfunction

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;        // cycles left in current state, minus one
  logic [CNT_W-1:0]  reps_r;       // windows left including the current one
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  gap_r;
  logic              first_win_r;  // high until window 0 has ended
  logic              dut_enable_r;
  logic [DATA_W-1:0] dut_a_r;
  logic [DATA_W-1:0] dut_b_r;
  logic              trig_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] result_r;
  logic              result_vld_r;
  logic [CNT_W-1:0]  valid_cnt_r;
  logic              overrun_r;

  logic [CNT_W-1:0]  len_in_s;
  logic [CNT_W-1:0]  reps_in_s;

  // Configuration values as they will be latched on an accepted start
  always_comb begin
    len_in_s  = at_least_one(bus.cfg_len);
    reps_in_s = at_least_one(bus.cfg_reps);
  end

  // Run sequencer with registered outputs and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      reps_r       <= CNT_ZERO;
      len_r        <= CNT_ZERO;
      gap_r        <= CNT_ZERO;
      first_win_r  <= 1'b0;
      dut_enable_r <= 1'b0;
      dut_a_r      <= {DATA_W{1'b0}};
      dut_b_r      <= {DATA_W{1'b0}};
      trig_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      result_r     <= {DATA_W{1'b0}};
      result_vld_r <= 1'b0;
      valid_cnt_r  <= CNT_ZERO;
      overrun_r    <= 1'b0;
    end else begin
      // Outputs follow the state one cycle later.
      dut_enable_r <= (state_r == ACTIVE);
      trig_r       <= (state_r == ACTIVE) && (TRIG_EVERY || first_win_r);
      busy_r       <= (state_r != IDLE);
      done_r       <= (state_r == DONE);

      // Capture is gated by the visible busy flag, so the DONE cycle is
      // the last one in which a unit result is taken.
      result_vld_r <= 1'b0;
      if (bus.dut_valid && busy_r) begin
        result_r     <= bus.dut_o0;
        result_vld_r <= 1'b1;
        if (valid_cnt_r != CNT_MAX) begin
          valid_cnt_r <= valid_cnt_r + CNT_ONE;
        end else begin
          valid_cnt_r <= valid_cnt_r;
        end
      end else begin
        result_r <= result_r;
      end

      if (bus.start && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        IDLE: begin
          if (bus.start) begin
            len_r       <= len_in_s;
            gap_r       <= bus.cfg_gap;
            reps_r      <= reps_in_s;
            dut_a_r     <= bus.op_a;
            dut_b_r     <= bus.op_b;
            first_win_r <= 1'b1;
            valid_cnt_r <= CNT_ZERO;
            overrun_r   <= 1'b0;
            if (bus.cfg_delay != CNT_ZERO) begin
              state_r <= DELAY;
              cnt_r   <= bus.cfg_delay - CNT_ONE;
            end else begin
              state_r <= ACTIVE;
              cnt_r   <= len_in_s - CNT_ONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DELAY: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= ACTIVE;
            cnt_r   <= len_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ACTIVE: begin
          if (cnt_r == CNT_ZERO) begin
            first_win_r <= 1'b0;
            if (reps_r > CNT_ONE) begin
              reps_r <= reps_r - CNT_ONE;
              if (gap_r != CNT_ZERO) begin
                state_r <= GAP;
                cnt_r   <= gap_r - CNT_ONE;
              end else begin
                state_r <= ACTIVE;
                cnt_r   <= len_r - CNT_ONE;
              end
            end else begin
              state_r <= DONE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= ACTIVE;
            cnt_r   <= len_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.dut_enable = dut_enable_r;
  assign bus.dut_a      = dut_a_r;
  assign bus.dut_b      = dut_b_r;
  assign bus.trig       = trig_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.result     = result_r;
  assign bus.result_vld = result_vld_r;
  assign bus.valid_cnt  = valid_cnt_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_sca_exec_window_ctrl.sv
// Directed bench for sca_exec_window_ctrl. Two instances share stimulus:
// one with TRIG_ALL=0 (bus0) and one with TRIG_ALL=1 (bus1). Expected
// window/done/busy timing is derived from the start edge k and D/L/G/R.
module tb_sca_exec_window_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sca_exec_window_ctrl_if #(.DATA_W(24), .CNT_W(8)) bus0 ();
  sca_exec_window_ctrl_if #(.DATA_W(24), .CNT_W(8)) bus1 ();

  assign bus1.start     = bus0.start;
  assign bus1.cfg_delay = bus0.cfg_delay;
  assign bus1.cfg_len   = bus0.cfg_len;
  assign bus1.cfg_gap   = bus0.cfg_gap;
  assign bus1.cfg_reps  = bus0.cfg_reps;
  assign bus1.op_a      = bus0.op_a;
  assign bus1.op_b      = bus0.op_b;
  assign bus1.dut_valid = bus0.dut_valid;
  assign bus1.dut_o0    = bus0.dut_o0;

  sca_exec_window_ctrl #(.DATA_W(24), .CNT_W(8), .TRIG_ALL(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  sca_exec_window_ctrl #(.DATA_W(24), .CNT_W(8), .TRIG_ALL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // True when cycle j (counted from the start edge) lies in an enable window.
  function automatic bit in_win(input int j, input int d, input int l, input int g,
                                input int r, input bit first_only);
    for (int w = 0; w < r; w++) begin
      if ((!first_only || w == 0) &&
          j >= 1 + d + w * (l + g) && j <= d + w * (l + g) + l) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One run: start at edge k, then check every cycle until one past done.
  // v1/v2: cycles at which dut_valid is sampled; ovr: cycle of a mid-run start.
  task automatic run(input int d, input int l, input int g, input int r,
                     input int v1, input logic [23:0] d1,
                     input int v2, input logic [23:0] d2,
                     input int ovr, input string name);
    int le;
    int re;
    int last;
    le   = (l == 0) ? 1 : l;
    re   = (r == 0) ? 1 : r;
    last = d + (re - 1) * (le + g) + le + 1;
    bus0.cfg_delay = 8'(d);
    bus0.cfg_len   = 8'(l);
    bus0.cfg_gap   = 8'(g);
    bus0.cfg_reps  = 8'(r);
    bus0.start     = 1'b1;
    @(posedge clk); #1;
    bus0.start     = 1'b0;
    for (int j = 1; j <= last + 1; j++) begin
      bus0.start = (j == ovr);
      if (j == ovr) bus0.op_a = 24'h777;
      bus0.dut_valid = (j == v1) || (j == v2);
      bus0.dut_o0    = (j == v1) ? d1 : d2;
      // cfg changes during the run must not matter
      bus0.cfg_len   = 8'd9;
      @(posedge clk); #1;
      bus0.start     = 1'b0;
      bus0.dut_valid = 1'b0;
      check_val($sformatf("%s en0 j=%0d", name, j), 32'(bus0.dut_enable), 32'(in_win(j, d, le, g, re, 1'b0)));
      check_val($sformatf("%s en1 j=%0d", name, j), 32'(bus1.dut_enable), 32'(in_win(j, d, le, g, re, 1'b0)));
      check_val($sformatf("%s trig0 j=%0d", name, j), 32'(bus0.trig), 32'(in_win(j, d, le, g, re, 1'b1)));
      check_val($sformatf("%s trig1 j=%0d", name, j), 32'(bus1.trig), 32'(in_win(j, d, le, g, re, 1'b0)));
      check_val($sformatf("%s busy j=%0d", name, j), 32'(bus0.busy), 32'(j <= last));
      check_val($sformatf("%s done j=%0d", name, j), 32'(bus0.done), 32'(j == last));
      check_val($sformatf("%s rvld j=%0d", name, j), 32'(bus0.result_vld), 32'((j == v1) || (j == v2)));
    end
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, " en"},   32'(bus0.dut_enable), 32'd0);
    check_val({name, " trig"}, 32'(bus0.trig),       32'd0);
    check_val({name, " busy"}, 32'(bus0.busy),       32'd0);
    check_val({name, " done"}, 32'(bus0.done),       32'd0);
    check_val({name, " a"},    32'(bus0.dut_a),      32'd0);
    check_val({name, " b"},    32'(bus0.dut_b),      32'd0);
    check_val({name, " res"},  32'(bus0.result),     32'd0);
    check_val({name, " rvld"}, 32'(bus0.result_vld), 32'd0);
    check_val({name, " vcnt"}, 32'(bus0.valid_cnt),  32'd0);
    check_val({name, " ovr"},  32'(bus0.overrun),    32'd0);
  endtask

  initial begin
    clk            = 1'b0;
    rst_n          = 1'b0;
    n_checks       = 0;
    n_errors       = 0;
    bus0.start     = 1'b0;
    bus0.cfg_delay = 8'd0;
    bus0.cfg_len   = 8'd0;
    bus0.cfg_gap   = 8'd0;
    bus0.cfg_reps  = 8'd0;
    bus0.op_a      = 24'h0;
    bus0.op_b      = 24'h0;
    bus0.dut_valid = 1'b0;
    bus0.dut_o0    = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Legacy six-cycle behaviour
    bus0.op_a = 24'h123;
    bus0.op_b = 24'h456;
    run(0, 6, 0, 1, 0, 24'h0, 0, 24'h0, 0, "legacy");
    check_val("legacy dut_a", 32'(bus0.dut_a), 32'h123);
    check_val("legacy dut_b", 32'(bus0.dut_b), 32'h456);

    // Delay, three windows with gaps, captures and a mid-run start
    run(3, 2, 4, 3, 3, 24'hABC, 9, 24'hDEF, 8, "multi");
    check_val("multi result",  32'(bus0.result),    32'hDEF);
    check_val("multi vcnt",    32'(bus0.valid_cnt), 32'd2);
    check_val("multi overrun", 32'(bus0.overrun),   32'd1);
    check_val("multi dut_a",   32'(bus0.dut_a),     32'h123);

    // Valid while idle is ignored
    bus0.dut_valid = 1'b1;
    bus0.dut_o0    = 24'h555;
    @(posedge clk); #1;
    bus0.dut_valid = 1'b0;
    check_val("idle rvld",   32'(bus0.result_vld), 32'd0);
    check_val("idle result", 32'(bus0.result),     32'hDEF);
    check_val("idle vcnt",   32'(bus0.valid_cnt),  32'd2);

    // Zero length and reps become a single one-cycle window
    run(0, 0, 0, 0, 0, 24'h0, 0, 24'h0, 0, "zero");
    check_val("zero overrun", 32'(bus0.overrun),   32'd0);
    check_val("zero vcnt",    32'(bus0.valid_cnt), 32'd0);
    check_val("zero dut_a",   32'(bus0.dut_a),     32'h777);

    // Contiguous windows: enable 6 cycles, trig0 only first 3
    run(0, 3, 0, 2, 0, 24'h0, 0, 24'h0, 0, "contig");

    // Reset in the middle of a window aborts the run
    bus0.cfg_delay = 8'd0;
    bus0.cfg_len   = 8'd5;
    bus0.cfg_reps  = 8'd1;
    bus0.start     = 1'b1;
    @(posedge clk); #1;
    bus0.start     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("abort en before", 32'(bus0.dut_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      check_val($sformatf("abort done j=%0d", j), 32'(bus0.done), 32'd0);
      check_val($sformatf("abort busy j=%0d", j), 32'(bus0.busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sca_exec_window_ctrl.md
# sca_exec_window_ctrl

Parametrised execution-window controller for side-channel measurement of the polynomial arithmetic unit on the SASEBO-GIII board. It replaces the fixed six-cycle working-flag generator with a programmable sequencer. A host start pulse launches a run: a programmable delay, then N repetitions of an enable window of programmable length, separated by programmable gaps. Operands are frozen for the whole run, a scope trigger is produced, and unit results are captured. It sits between the local-bus interface block and the arithmetic unit.

## Interface
- DATA_W, 24, operand/result width (matches arithmetic unit ports)
- CNT_W, 8, width of delay/length/gap/repetition config fields
- TRIG_ALL, 0, 0: trig only during first window of a run; 1: trig during every window
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled on clk (level; acted on only in IDLE)
- cfg_delay  in  CNT_W  cycles between start and first window
- cfg_len  in  CNT_W  window length in cycles (0 treated as 1)
- cfg_gap  in  CNT_W  idle cycles between windows
- cfg_reps  in  CNT_W  number of windows (0 treated as 1)
- op_a, op_b  in  DATA_W  operands from bus interface
- dut_valid  in  1  arithmetic unit output valid
- dut_o0  in  DATA_W  arithmetic unit output
- dut_enable  out  1  arithmetic unit enable (registered)
- dut_a, dut_b  out  DATA_W  frozen operands to unit
- trig  out  1  scope trigger (registered)
- busy  out  1  high from state leaving IDLE until return to IDLE
- done  out  1  one-cycle pulse at end of run
- result  out  DATA_W  last captured dut_o0
- result_vld  out  1  one-cycle pulse when result updates
- valid_cnt  out  CNT_W  dut_valid pulses counted in current run (saturating)
- overrun  out  1  sticky: start seen while busy; cleared by next accepted start

## Operation
- States: IDLE, DELAY, ACTIVE, GAP, DONE.
- IDLE: start=1 → latch cfg_* (0→1 substitution for len/reps applied at latch), latch op_a/op_b into dut_a/dut_b, clear valid_cnt, clear overrun, load rep counter. Next state: DELAY if delay>0, else ACTIVE.
- DELAY: count delay cycles → ACTIVE.
- ACTIVE: count len cycles; at last cycle, if reps remaining >1 → GAP (or ACTIVE again directly if gap=0), else DONE.
- GAP: count gap cycles → ACTIVE.
- DONE: one cycle, done=1 → IDLE.
- dut_enable = registered (state==ACTIVE). trig = dut_enable during window 0, or during every window if TRIG_ALL=1.
- dut_a/dut_b change only on an accepted start; they are held through the whole run and after it.
- dut_valid=1 while busy: result←dut_o0, result_vld pulse, valid_cnt+1 (saturates at 2^CNT_W−1). dut_valid in IDLE is ignored.
- start=1 in any state other than IDLE sets overrun and is otherwise ignored. start held high continuously produces back-to-back runs, each beginning the cycle after DONE.

## Timing
- Reset (async, rst_n=0): state IDLE, all outputs 0, all counters 0. Reset asserted mid-run aborts the run immediately, with no done pulse.
- Start sampled at edge k, delay D, length L, gap G, R reps:
  - Window r: dut_enable high for edges k+1+D+r(L+G) through k+D+r(L+G)+L.
  - done is high for the cycle after the last window's final enable cycle.
  - busy is high from edge k+1 through the done cycle inclusive.
- D=0 with L=6 and R=1 reproduces the legacy behaviour: enable for 6 cycles starting one cycle after start.
- G=0: windows are contiguous and enable stays high for R·L cycles. Counters still advance per window, so trig with TRIG_ALL=0 drops after the first L cycles.
- dut_valid and the window end occurring in the same cycle: the capture still occurs. Capture continues through the DONE cycle only.
- The config latch makes mid-run cfg_* changes invisible until the next start.

## Test plan
- Reset then start with D=0, L=6, G=0, R=1, op_a=0x123, op_b=0x456 → enable high 6 cycles starting at k+1; dut_a=0x123, dut_b=0x456; done at k+7; busy k+1..k+7.
- D=3, L=2, G=4, R=3, TRIG_ALL=1 → enable windows at k+4..k+5, k+10..k+11, k+16..k+17; trig identical to enable; done at k+18.
- Same configuration with TRIG_ALL=0 → trig only at k+4..k+5.
- Drive dut_valid with dut_o0=0xABC at k+3 and with 0xDEF at k+9 → result=0xDEF, two result_vld pulses, valid_cnt=2. dut_valid at k+30, after the run → no change.
- Start again at k+8 mid-run and change op_a → overrun=1, dut_a unchanged, timing unaffected. The next accepted start clears overrun.
- cfg_len=0, cfg_reps=0 → a single 1-cycle window. Assert rst_n=0 mid-window → all outputs 0 at once, state IDLE, no done.
